// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals shared by the
// single-port memory arbiter and its surroundings.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          fetch_hold;

   logic          ls_req;
   logic          ls_wen;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata;
   logic          ls_gnt;
   logic          ls_rvalid;
   logic [DW-1:0] ls_rdata;

   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // Arbiter side of the bundle
   modport slave (
      input  if_req, if_addr, ls_req, ls_wen, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, fetch_hold,
             ls_gnt, ls_rvalid, ls_rdata,
             mem_wen, mem_addr, mem_wdata
   );

   // Requesters and memory side of the bundle
   modport master (
      output if_req, if_addr, ls_req, ls_wen, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, fetch_hold,
             ls_gnt, ls_rvalid, ls_rdata,
             mem_wen, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Load/store wins by default; a saturating starvation counter forces a
// fetch grant after STARVE_MAX consecutive denied fetch cycles. Read data
// returns one cycle after the grant and is steered by a response tag.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_LS   = 2'd2
   } rtag_t;

   rtag_t         r_rtag;
   rtag_t         w_rtagNext;
   logic [3:0]    r_starveCnt;
   logic [3:0]    w_starveNext;

   logic          w_ifForce;
   logic          w_ifGnt;
   logic          w_lsGnt;
   logic          w_memWen;
   logic [AW-1:0] w_memAddr;
   logic [DW-1:0] w_memWdata;
   logic          w_ifRvalid;
   logic          w_lsRvalid;

   // Grant decision: fetch wins when load/store is idle or when fetch has
   // already been denied STARVE_MAX cycles in a row; otherwise load/store.
   always_comb begin
      w_ifForce = bus.if_req && (r_starveCnt == STARVE_LIMIT);
      w_ifGnt   = bus.if_req && (w_ifForce || !bus.ls_req);
      w_lsGnt   = bus.ls_req && !w_ifGnt;
   end

   // Memory port drive; everything is held at zero when nobody owns the port
   // so that a write can never be issued without a load/store grant.
   always_comb begin
      w_memWen   = 1'b0;
      w_memAddr  = '0;
      w_memWdata = '0;
      if (w_ifGnt) begin
         w_memAddr = bus.if_addr;
      end else if (w_lsGnt) begin
         w_memWen   = bus.ls_wen;
         w_memAddr  = bus.ls_addr;
         w_memWdata = bus.ls_wdata;
      end
   end

   // Next starvation count and next response owner. Stores take no tag
   // because the grant itself is their acknowledge.
   always_comb begin
      w_starveNext = r_starveCnt;
      w_rtagNext   = TAG_NONE;
      if (!bus.if_req || w_ifGnt) begin
         w_starveNext = 4'd0;
      end else if (r_starveCnt != STARVE_LIMIT) begin
         w_starveNext = r_starveCnt + 4'd1;
      end
      if (w_ifGnt) begin
         w_rtagNext = TAG_IF;
      end else if (w_lsGnt && !bus.ls_wen) begin
         w_rtagNext = TAG_LS;
      end
   end

   // State registers; reset discards any in-flight response immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rtag      <= TAG_NONE;
         r_starveCnt <= 4'd0;
      end else begin
         r_rtag      <= w_rtagNext;
         r_starveCnt <= w_starveNext;
      end
   end

   // Response steering: the memory data of this cycle belongs to whoever
   // was granted a read last cycle; the other data output stays at zero.
   always_comb begin
      w_ifRvalid = (r_rtag == TAG_IF);
      w_lsRvalid = (r_rtag == TAG_LS);
   end

   assign bus.if_gnt     = w_ifGnt;
   assign bus.ls_gnt     = w_lsGnt;
   assign bus.fetch_hold = bus.if_req && !w_ifGnt;
   assign bus.mem_wen    = w_memWen;
   assign bus.mem_addr   = w_memAddr;
   assign bus.mem_wdata  = w_memWdata;
   assign bus.if_rvalid  = w_ifRvalid;
   assign bus.ls_rvalid  = w_lsRvalid;
   assign bus.if_rdata   = w_ifRvalid ? bus.mem_rdata : '0;
   assign bus.ls_rdata   = w_lsRvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_mem_port_arbiter;

   localparam int AW         = 32;
   localparam int DW         = 32;
   localparam int STARVE_MAX = 3;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   // Reference model state: consecutive denied fetch cycles and which
   // requester (0 none, 1 fetch, 2 load) is owed read data next cycle.
   int   mdlDenied;
   int   mdlOwner;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs on the falling edge, checks every output
   // against the model, then advances the model to the next cycle.
   task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                                input logic lsReq, input logic lsWen,
                                input logic [31:0] lsAddr,
                                input logic [31:0] lsWdata,
                                input logic [31:0] memRdata);
      logic        expIfGnt;
      logic        expLsGnt;
      logic [31:0] expAddr;
      @(negedge clk);
      bus.if_req    = ifReq;
      bus.if_addr   = ifAddr;
      bus.ls_req    = lsReq;
      bus.ls_wen    = lsWen;
      bus.ls_addr   = lsAddr;
      bus.ls_wdata  = lsWdata;
      bus.mem_rdata = memRdata;
      #1;
      expIfGnt = ifReq && (!lsReq || mdlDenied >= STARVE_MAX);
      expLsGnt = lsReq && !expIfGnt;
      expAddr  = expIfGnt ? ifAddr : (expLsGnt ? lsAddr : 32'h0);
      checkOutput("if_gnt", 32'(bus.if_gnt), 32'(expIfGnt));
      checkOutput("ls_gnt", 32'(bus.ls_gnt), 32'(expLsGnt));
      checkOutput("fetch_hold", 32'(bus.fetch_hold), 32'(ifReq && !expIfGnt));
      checkOutput("mem_wen", 32'(bus.mem_wen), 32'(expLsGnt && lsWen));
      checkOutput("mem_addr", bus.mem_addr, expAddr);
      if (!expIfGnt)
         checkOutput("mem_wdata", bus.mem_wdata, expLsGnt ? lsWdata : 32'h0);
      checkOutput("if_rvalid", 32'(bus.if_rvalid), 32'(mdlOwner == 1));
      checkOutput("if_rdata", bus.if_rdata, (mdlOwner == 1) ? memRdata : 32'h0);
      checkOutput("ls_rvalid", 32'(bus.ls_rvalid), 32'(mdlOwner == 2));
      checkOutput("ls_rdata", bus.ls_rdata, (mdlOwner == 2) ? memRdata : 32'h0);
      mdlOwner  = expIfGnt ? 1 : ((expLsGnt && !lsWen) ? 2 : 0);
      mdlDenied = (ifReq && !expIfGnt) ? ((mdlDenied < STARVE_MAX) ? mdlDenied + 1 : STARVE_MAX) : 0;
   endtask

   initial begin
      logic [4:0] starvePattern;
      checks    = 0;
      failures  = 0;
      mdlDenied = 0;
      mdlOwner  = 0;
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.ls_req    = 1'b0;
      bus.ls_wen    = 1'b0;
      bus.ls_addr   = '0;
      bus.ls_wdata  = '0;
      bus.mem_rdata = 32'hA5A5A5A5;
      #2;
      checkOutput("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
      checkOutput("rst_ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
      checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
      checkOutput("rst_mem_wen", 32'(bus.mem_wen), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Fetch alone: granted at once, instruction word returned next cycle
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      checkOutput("fetch_gnt", 32'(bus.if_gnt), 32'h1);
      checkOutput("fetch_hold0", 32'(bus.fetch_hold), 32'h0);
      checkOutput("fetch_addr", bus.mem_addr, 32'h10);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF);
      checkOutput("fetch_rvalid", 32'(bus.if_rvalid), 32'h1);
      checkOutput("fetch_rdata", bus.if_rdata, 32'hDEADBEEF);

      // Conflict: load wins, fetch is held, load data comes back
      applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
      checkOutput("conf_ls_gnt", 32'(bus.ls_gnt), 32'h1);
      checkOutput("conf_hold", 32'(bus.fetch_hold), 32'h1);
      checkOutput("conf_addr", bus.mem_addr, 32'h40);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D);
      checkOutput("conf_ls_rvalid", 32'(bus.ls_rvalid), 32'h1);
      checkOutput("conf_ls_rdata", bus.ls_rdata, 32'h0BADF00D);
      checkOutput("conf_if_rvalid", 32'(bus.if_rvalid), 32'h0);

      // Starvation: fetch wins only on the fourth contested cycle
      starvePattern = 5'b01000;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, $urandom);
         checkOutput($sformatf("starve_if_gnt%0d", i), 32'(bus.if_gnt), 32'(starvePattern[i]));
      end

      // Store: write strobe and data in the grant cycle, no response after
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0);
      checkOutput("store_wen", 32'(bus.mem_wen), 32'h1);
      checkOutput("store_wdata", bus.mem_wdata, 32'h1234);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5555AAAA);
      checkOutput("store_no_rvalid", 32'(bus.ls_rvalid), 32'h0);

      // Gap in the fetch request clears the starvation count
      applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h204, 32'h0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h208, 32'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h20C, 32'h0, 32'h0);
         checkOutput($sformatf("gap_if_gnt%0d", i), 32'(bus.if_gnt), 32'(starvePattern[i]));
      end

      // Reset during an outstanding load drops the response immediately
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D);
      @(posedge clk);
      #2;
      checkOutput("mid_ls_rvalid", 32'(bus.ls_rvalid), 32'h1);
      bus.ls_req = 1'b0;
      rst        = 1'b1;
      #1;
      checkOutput("async_ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
      checkOutput("async_ls_rdata", bus.ls_rdata, 32'h0);
      @(negedge clk);
      rst       = 1'b0;
      mdlDenied = 0;
      mdlOwner  = 0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678);
      checkOutput("post_rst_ls_rvalid", 32'(bus.ls_rvalid), 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), $urandom,
                       1'($urandom_range(0, 3) != 0), 1'($urandom),
                       $urandom, $urandom, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
